sprite_region_ctrl: RTL

SPRITE_REGION_CTRL -- requirements
Module: sprite_region_ctrl

---
 rtl/sprite_region_ctrl.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/sprite_region_ctrl.sv
// rtl/sprite_region_ctrl.sv - per-sprite hit/fly/gone state machine with registered region test
//
// Purpose:
//   For each of NUM_SPRITES sprites, decides whether the current pixel lies
//   inside the sprite's bounding box and whether the sprite is drawn in its
//   normal or flying appearance. Life-cycle state only advances on frame_tick,
//   so a sprite never changes appearance in the middle of a frame.
//
// Ports:
//   Clk          in   system clock, rising edge
//   Reset        in   synchronous, active-high reset
//   frame_tick   in   one-cycle pulse at vblank start
//   DrawX/DrawY  in   current pixel coordinate (10 bits each)
//   center_x/y   in   packed sprite centres, sprite i at [10i+9:10i]
//   hit_in       in   per-sprite hit pulse
//   respawn_in   in   per-sprite respawn pulse
//   show_normal  out  pixel inside sprite i and sprite i ALIVE
//   show_fly     out  pixel inside sprite i and sprite i FLY
//   sprite_any   out  any sprite visible at this pixel
//   win_id       out  lowest-index visible sprite
//   rel_x/rel_y  out  winner-relative ROM offset
//   sprite_state out  2 bits per sprite: 00 ALIVE, 01 FLY, 10 GONE

module sprite_region_ctrl #(
    parameter int NUM_SPRITES = 2,
    parameter int HALF_W      = 42,
    parameter int HALF_H      = 46,
    parameter int FLY_FRAMES  = 60,
    parameter int OFF_W       = 7
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      frame_tick,
    input  logic [9:0]                DrawX,
    input  logic [9:0]                DrawY,
    input  logic [10*NUM_SPRITES-1:0] center_x,
    input  logic [10*NUM_SPRITES-1:0] center_y,
    input  logic [NUM_SPRITES-1:0]    hit_in,
    input  logic [NUM_SPRITES-1:0]    respawn_in,
    output logic [NUM_SPRITES-1:0]    show_normal,
    output logic [NUM_SPRITES-1:0]    show_fly,
    output logic                      sprite_any,
    output logic [2:0]                win_id,
    output logic [OFF_W-1:0]          rel_x,
    output logic [OFF_W-1:0]          rel_y,
    output logic [2*NUM_SPRITES-1:0]  sprite_state
);

    localparam logic [1:0] ST_ALIVE = 2'b00;
    localparam logic [1:0] ST_FLY   = 2'b01;
    localparam logic [1:0] ST_GONE  = 2'b10;

    localparam logic [7:0]         FLY_LOAD = 8'(FLY_FRAMES - 1);
    localparam logic signed [10:0] HW       = 11'(HALF_W);
    localparam logic signed [10:0] HH       = 11'(HALF_H);

    // Life-cycle state
    logic [1:0]             state_q    [NUM_SPRITES];
    logic [1:0]             state_d    [NUM_SPRITES];
    logic [7:0]             cnt_q      [NUM_SPRITES];
    logic [7:0]             cnt_d      [NUM_SPRITES];
    logic [NUM_SPRITES-1:0] pend_hit_q;
    logic [NUM_SPRITES-1:0] pend_hit_d;
    logic [NUM_SPRITES-1:0] pend_rsp_q;
    logic [NUM_SPRITES-1:0] pend_rsp_d;

    // Registered pixel path
    logic [NUM_SPRITES-1:0] show_normal_q;
    logic [NUM_SPRITES-1:0] show_normal_d;
    logic [NUM_SPRITES-1:0] show_fly_q;
    logic [NUM_SPRITES-1:0] show_fly_d;
    logic                   sprite_any_q;
    logic                   sprite_any_d;
    logic [2:0]             win_id_q;
    logic [2:0]             win_id_d;
    logic [OFF_W-1:0]       rel_x_q;
    logic [OFF_W-1:0]       rel_x_d;
    logic [OFF_W-1:0]       rel_y_q;
    logic [OFF_W-1:0]       rel_y_d;

    logic signed [10:0]     dx_c   [NUM_SPRITES];
    logic signed [10:0]     dy_c   [NUM_SPRITES];
    logic [NUM_SPRITES-1:0] inside_c;

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                state_q[i] <= ST_ALIVE;
                cnt_q[i]   <= 8'd0;
            end
            pend_hit_q    <= '0;
            pend_rsp_q    <= '0;
            show_normal_q <= '0;
            show_fly_q    <= '0;
            sprite_any_q  <= 1'b0;
            win_id_q      <= 3'd0;
            rel_x_q       <= '0;
            rel_y_q       <= '0;
        end else begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            pend_hit_q    <= pend_hit_d;
            pend_rsp_q    <= pend_rsp_d;
            show_normal_q <= show_normal_d;
            show_fly_q    <= show_fly_d;
            sprite_any_q  <= sprite_any_d;
            win_id_q      <= win_id_d;
            rel_x_q       <= rel_x_d;
            rel_y_q       <= rel_y_d;
        end
    end

    // Next-state logic. Pulses arriving in the frame_tick cycle are folded in
    // directly so they are consumed by that same tick; all pending flags are
    // dropped on every tick whether or not the current state used them.
    always_comb begin
        pend_hit_d = pend_hit_q | hit_in;
        pend_rsp_d = pend_rsp_q | respawn_in;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
        end
        if (frame_tick) begin
            pend_hit_d = '0;
            pend_rsp_d = '0;
            for (int i = 0; i < NUM_SPRITES; i++) begin
                case (state_q[i])
                    ST_ALIVE: begin
                        if (pend_hit_q[i] | hit_in[i]) begin
                            state_d[i] = ST_FLY;
                            cnt_d[i]   = FLY_LOAD;
                        end
                    end
                    ST_FLY: begin
                        if (cnt_q[i] == 8'd0) begin
                            state_d[i] = ST_GONE;
                        end else begin
                            cnt_d[i] = cnt_q[i] - 8'd1;
                        end
                    end
                    ST_GONE: begin
                        if (pend_rsp_q[i] | respawn_in[i]) begin
                            state_d[i] = ST_ALIVE;
                            cnt_d[i]   = 8'd0;
                        end
                    end
                    default: begin
                        state_d[i] = ST_ALIVE;
                        cnt_d[i]   = 8'd0;
                    end
                endcase
            end
        end
    end

    // Output logic: region test against the registered state, winner select.
    // Coordinates are zero-extended to 11 bits before subtracting so a far
    // pixel cannot wrap back into range.
    always_comb begin
        show_normal_d = '0;
        show_fly_d    = '0;
        sprite_any_d  = 1'b0;
        win_id_d      = 3'd0;
        rel_x_d       = '0;
        rel_y_d       = '0;
        inside_c      = '0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            dx_c[i] = $signed({1'b0, DrawX}) - $signed({1'b0, center_x[10*i +: 10]});
            dy_c[i] = $signed({1'b0, DrawY}) - $signed({1'b0, center_y[10*i +: 10]});
            inside_c[i] = (dx_c[i] >= -HW) && (dx_c[i] <= HW) &&
                          (dy_c[i] >= -HH) && (dy_c[i] <= HH);
            show_normal_d[i] = inside_c[i] && (state_q[i] == ST_ALIVE);
            show_fly_d[i]    = inside_c[i] && (state_q[i] == ST_FLY);
        end
        sprite_any_d = |(show_normal_d | show_fly_d);
        // Walk from the top index down so the lowest visible index wins.
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (show_normal_d[i] || show_fly_d[i]) begin
                win_id_d = 3'(i);
                rel_x_d  = OFF_W'(dx_c[i] + HW);
                rel_y_d  = OFF_W'(dy_c[i] + HH);
            end
        end
    end

    always_comb begin
        sprite_state = '0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            sprite_state[2*i +: 2] = state_q[i];
        end
    end

    assign show_normal = show_normal_q;
    assign show_fly    = show_fly_q;
    assign sprite_any  = sprite_any_q;
    assign win_id      = win_id_q;
    assign rel_x       = rel_x_q;
    assign rel_y       = rel_y_q;

endmodule
